addr_seq_gen: RTL

Parametrised, level-indexed ROM address sequencer for sprite/path/formation data. It is the successor to the fixed 12-bit level address generator. Each level owns a segment of ROM; the block walks through it at a programmable rate, in loop, ping-pong, one-shot or hold mode, with start, pause and done handshakes. It sits between game control (level/mode/start) and the graphics/path ROMs, in the `pclk` domain.

---
 rtl/addr_seq_pkg.sv | 8 +
 rtl/addr_seq_gen_if.sv | 18 +
 rtl/addr_seq_prescaler.sv | 18 +
 rtl/addr_seq_gen.sv | 82 ++++++++
 4 files changed

// File: rtl/addr_seq_pkg.sv
// addr_seq_pkg: mode encodings and FSM state type for the ROM address sequencer
package addr_seq_pkg;
  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_PINGPONG = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/addr_seq_gen_if.sv
// addr_seq_gen_if: game-control side request signals and ROM-side address outputs
interface addr_seq_gen_if #(
  parameter int ADDR_W = 12,
  parameter int LVL_W  = 3,
  parameter int SEG_W  = 8
);
  logic [LVL_W-1:0]  level;
  logic [1:0]        mode;
  logic [SEG_W-1:0]  len;
  logic              start;
  logic              pause;
  logic [ADDR_W-1:0] address_out;
  logic              valid;
  logic              step;
  logic              done;
  modport master (output level, mode, len, start, pause, input address_out, valid, step, done);
  modport slave  (input level, mode, len, start, pause, output address_out, valid, step, done);
endinterface

// File: rtl/addr_seq_prescaler.sv
// addr_seq_prescaler: counts 0..DIV-1 while enabled, tick in the terminal-count cycle
module addr_seq_prescaler #(
  parameter int DIV = 400000
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(DIV - 1);
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/addr_seq_gen.sv
// addr_seq_gen: level-indexed ROM address sequencer (loop/ping-pong/one-shot/hold)
// ADDR_SEQ_PINGPONG_EN builds ping-pong mode; otherwise mode 01 runs as loop.
module addr_seq_gen
  import addr_seq_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LVL_W  = 3,
  parameter int SEG_W  = 8,
  parameter int DIV    = 400000
) (
  input logic pclk,
  input logic rst_n,
  addr_seq_gen_if.slave bus
);
  state_t           state, nxt_state;
  logic [LVL_W-1:0] level_q, nxt_level;
  logic [SEG_W-1:0] len_q, idx, nxt_idx, adv_idx, loop_idx, wrap_idx;
  logic             restart, en, tick, at_top;
`ifdef ADDR_SEQ_PINGPONG_EN
  logic             dir, mode_chg, go_down;
  logic [1:0]       mode_q;
  logic [SEG_W-1:0] pp_idx;
`endif
  addr_seq_prescaler #(.DIV(DIV)) u_pre (
    .pclk (pclk),
    .rst_n(rst_n),
    .clr  (restart),
    .en   (en),
    .tick (tick)
  );
  always_comb begin
    restart  = bus.start || (state != ST_IDLE && bus.level != level_q);
    en       = state == ST_RUN && !bus.pause;
    at_top   = idx == len_q;
    loop_idx = at_top ? '0 : idx + 1'b1;
`ifdef ADDR_SEQ_PINGPONG_EN
    mode_chg = bus.mode != mode_q;
    go_down  = (dir && !mode_chg) ? idx != '0 : at_top;
    pp_idx   = len_q == '0 ? idx : go_down ? idx - 1'b1 : idx + 1'b1;
    wrap_idx = bus.mode == MODE_PINGPONG ? pp_idx : loop_idx;
`else
    wrap_idx = loop_idx;
`endif
    adv_idx   = bus.mode == MODE_HOLD ? idx :
                bus.mode == MODE_ONESHOT ? (at_top ? idx : idx + 1'b1) : wrap_idx;
    nxt_idx   = restart ? '0 : tick ? adv_idx : idx;
    nxt_level = restart ? bus.level : level_q;
    nxt_state = restart ? ST_RUN :
                (tick && bus.mode == MODE_ONESHOT && at_top) ? ST_DONE : state;
  end
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      state           <= ST_IDLE;
      level_q         <= '0;
      len_q           <= '0;
      idx             <= '0;
      bus.address_out <= '0;
      bus.valid       <= 1'b0;
      bus.step        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      state           <= nxt_state;
      level_q         <= nxt_level;
      idx             <= nxt_idx;
      if (bus.start) len_q <= bus.len;
      bus.address_out <= nxt_state == ST_IDLE ? '0 : ADDR_W'({nxt_level, nxt_idx});
      bus.valid       <= nxt_state != ST_IDLE;
      bus.step        <= !restart && tick && adv_idx != idx;
      bus.done        <= nxt_state == ST_DONE;
    end
`ifdef ADDR_SEQ_PINGPONG_EN
  // direction only matters in ping-pong; any other mode or a mode switch parks it at up
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      dir    <= 1'b0;
      mode_q <= MODE_LOOP;
    end else begin
      mode_q <= bus.mode;
      dir    <= (restart || bus.mode != MODE_PINGPONG) ? 1'b0 : tick ? go_down : dir && !mode_chg;
    end
`endif
endmodule
